// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared types for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;
   typedef enum logic {IDLE, HOLD} rr_arb_state_t;
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotating-priority selector, first requester at or after ptr wins.
module rr_priority_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);
   int j;
   always_comb begin
      gnt = '0;
      idx = '0;
      any = |req;
      j   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter steering N_REQ requesters through one mux into a registered output.
// Define RR_MUX_ARB_LOCK_EN for packet lock (req_last port, HOLD state).
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
`ifdef RR_MUX_ARB_LOCK_EN
   input  logic [N_REQ-1:0]         req_last,
`endif
   output logic [N_REQ-1:0]         req_ready,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [$clog2(N_REQ)-1:0] out_src,
   input  logic                     out_ready
);
   localparam int IW = $clog2(N_REQ);
   rr_arb_state_t    r_state;
   logic [IW-1:0]    r_ptr, r_lock, r_out_src;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [N_REQ-1:0] w_pgnt, w_gnt;
   logic [IW-1:0]    w_idx, w_sel, w_nxt;
   logic             w_any, w_hold, w_can_load, w_xfer, w_last;
   logic [WIDTH-1:0] w_data;
   rr_priority_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req (req_valid),
      .ptr (r_ptr),
      .gnt (w_pgnt),
      .idx (w_idx),
      .any (w_any)
   );
   assign w_hold     = r_state == HOLD;
   assign w_can_load = !r_out_valid || out_ready;
   assign w_sel      = w_hold ? r_lock : w_idx;
   assign w_gnt      = w_hold ? (N_REQ'(1) << r_lock) : (w_pgnt & {N_REQ{w_any}});
   assign req_ready  = (w_can_load && !rst) ? w_gnt : '0;
   assign w_xfer     = |(req_valid & req_ready);
   assign w_data     = req_data[w_sel*WIDTH +: WIDTH];
   assign w_nxt      = (w_sel == IW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
`ifdef RR_MUX_ARB_LOCK_EN
   assign w_last     = req_last[w_sel];
`else
   assign w_last     = 1'b1;
`endif
   // The pointer only advances at packet end, so a locked packet never loses its turn.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_ptr       <= '0;
         r_lock      <= '0;
         r_state     <= IDLE;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_src   <= w_sel;
         r_lock      <= w_sel;
         r_state     <= w_last ? IDLE : HOLD;
         if (w_last) r_ptr <= w_nxt;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one N-input data multiplexer between `N_REQ` valid/ready requesters. It drives a single registered output channel. Each cycle it selects one requester, steers that requester's data through the shared mux, and captures it into the output register. It sits between several producer blocks and one consumer, and owns the mux select so that no requester drives the shared path directly.

## Interface
- `N_REQ`, default 4: number of requesters; legal range ≥ 2, not required to be a power of two.
- `WIDTH`, default 8: data width per requester.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input `N_REQ`: per-requester valid.
- `req_data` input `N_REQ*WIDTH`: flattened data; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_last` input `N_REQ`: last beat of packet; present only with `RR_MUX_ARB_LOCK_EN`.
- `req_ready` output `N_REQ`: per-requester ready; at most one bit high in any cycle.
- `out_valid` output 1: output register holds a beat.
- `out_data` output `WIDTH`: registered beat.
- `out_src` output `$clog2(N_REQ)`: index of the requester that supplied `out_data`.
- `out_ready` input 1: consumer accepts the beat.

## Operation
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - Priority pointer `ptr`=0.
  - State=`IDLE`.
- `can_load` = `!out_valid || out_ready`.
- Winner: the first index i, scanning `ptr, ptr+1, …, N_REQ-1, 0, …` cyclically, with `req_valid[i]`=1. No valid requester means no winner.
- In `IDLE`, `req_ready[i]` = `can_load && winner exists && i==winner`.
- A transfer occurs when `req_valid[i] && req_ready[i]`. On a transfer:
  - `out_data` ← `req_data[i]`, `out_src` ← i, `out_valid` ← 1.
  - `ptr` ← `(i+1) mod N_REQ`. Wrap from `N_REQ-1` goes to 0.
- Output register update:
  - If there is no transfer and `out_ready`=1, `out_valid` ← 0.
  - If there is no transfer and `out_ready`=0, the register holds.
- `req_ready` is combinational from `req_valid`, `ptr`, state, `out_valid` and `out_ready`. `req_ready` never depends on `req_data`.
- Requesters must hold `req_valid` and `req_data` until the handshake completes. The arbiter may move the grant to another requester while a requester waits.
- Simultaneous `out_ready` consumption and a new transfer in the same cycle is legal: the register is overwritten and `out_valid` stays 1.

## Timing
- Latency: one cycle from the accepting edge to `out_valid`/`out_data`.
- Throughput: one beat per cycle while `out_ready`=1.
- Fairness: with all requesters continuously valid, each requester receives exactly one beat per `N_REQ` beats.
- Backpressure: while `out_valid`=1 and `out_ready`=0:
  - all `req_ready` bits are 0;
  - `out_data` and `out_src` are stable.
- `rst` asserted in any cycle:
  - next-edge state equals the reset values above;
  - an in-flight output beat is dropped;
  - `req_ready` is 0 during the reset cycle.

## Configuration
- `RR_MUX_ARB_LOCK_EN` defined: packet lock.
  - Adds the `req_last` port and a `HOLD` state.
  - A transfer with `req_last[i]`=0 moves the block to `HOLD` with the locked index = i.
  - In `HOLD`, `req_ready[i]` = `can_load && i==locked`, and no other requester is granted. This holds even if the locked requester drops `req_valid`; the arbiter then waits.
  - `ptr` is not updated on non-last beats.
  - A transfer with `req_last`=1 sets `ptr` ← locked+1 and returns to `IDLE`.
  - In `IDLE`, a beat with `req_last`=1 behaves as a single-beat packet.
- `RR_MUX_ARB_LOCK_EN` undefined:
  - no `req_last` port;
  - the state is always `IDLE`;
  - every beat is an independent grant.

## Structure
- Package `rr_mux_arbiter_pkg` holds the state typedef `rr_arb_state_t` (`IDLE`, `HOLD`).
- Sub-module `rr_priority_pick`: combinational rotating-priority selector.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `gnt`, index, and `any`.
- The top level contains the data mux (indexed by the winner), the output register, `ptr`, and the FSM.

## Test plan
All scenarios use `N_REQ`=4 and `WIDTH`=8.
- Reset: hold `rst` 2 cycles with all `req_valid`=4'b1111 → `out_valid`=0, `req_ready`=0, `out_src`=0 throughout; after release, the first beat comes from requester 0.
- Full round-robin: all valid continuously, data 8'hA0/A1/A2/A3, `out_ready`=1 → `out_data` sequence A0,A1,A2,A3,A0 on consecutive cycles, first beat one cycle after `rst` falls.
- Backpressure: `out_ready`=0 for 3 cycles with `out_valid`=1 → `out_data` and `out_src` unchanged and `req_ready`=0 for all 3 cycles; beats resume with the next requester in order.
- Pointer wrap/skip:
  - only requester 2 valid with `ptr`=0 → requester 2 granted, after which `ptr`=3;
  - then requesters 1 and 3 valid → requester 3 wins, then requester 1.
- Lock (macro defined):
  - requester 0 sends a 3-beat packet 8'h10, 11, 12, with `req_last` on 8'h12; requester 1 is valid throughout with 8'h20;
  - → `out_src` sequence 0,0,0,1;
  - → requester 1 is not granted during `HOLD`, even while requester 0 idles for 1 cycle mid-packet.
- Reset mid-packet (macro defined): `rst` asserted after beat 1 of a packet → next cycle `out_valid`=0, state `IDLE`, `ptr`=0; requester 1 can then be granted normally.
